// File: rtl/pll_phase_detector.sv
// Phase/frequency detector: ref/fb edges are synchronised in 3 cycles and outputs are registered one cycle later.
// There is no backpressure. phase_err and err_valid are presented once and are not held for a consumer.
module pll_phase_detector #(
   parameter int CNT_W      = 8,
   parameter int LOCK_TOL   = 2,
   parameter int LOCK_COUNT = 16
) (
   input  logic             sys_clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             ref_in,
   input  logic             fb_in,
   output logic             up,
   output logic             dn,
   output logic [CNT_W:0]   phase_err,
   output logic             err_valid,
   output logic             slip,
   output logic             locked
);
   localparam logic [CNT_W-1:0] MAX_WAIT = '1;
   localparam logic [CNT_W-1:0] ONE      = 1;
   localparam logic [CNT_W:0]   TOL      = (CNT_W+1)'(LOCK_TOL);
   localparam logic [7:0]       LOCK_MAX = 8'(LOCK_COUNT);

   typedef enum logic [1:0] {IDLE = 2'd0, REF_LEAD = 2'd1, FB_LEAD = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [2:0]       ref_sh_q, ref_sh_d, fb_sh_q, fb_sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       lock_cnt_q, lock_cnt_d;
   logic [CNT_W:0]   err_q, err_d;
   logic             up_q, up_d, dn_q, dn_d;
   logic             ev_q, ev_d, slip_q, slip_d, locked_q, locked_d;
   logic             ref_e, fb_e;
   logic [CNT_W:0]   lead_mag, err_abs;

   // bit 0 is the first sync stage, bit 1 the synchronised level, bit 2 the delay flop
   assign ref_e    = ref_sh_q[1] & ~ref_sh_q[2];
   assign fb_e     = fb_sh_q[1] & ~fb_sh_q[2];
   assign lead_mag = {1'b0, cnt_q};

   always_comb begin
      ref_sh_d   = {ref_sh_q[1:0], ref_in};
      fb_sh_d    = {fb_sh_q[1:0], fb_in};
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      ev_d       = 1'b0;
      slip_d     = 1'b0;
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      err_abs    = '0;
      case (state_q)
         IDLE: begin
            if (ref_e && fb_e) begin
               err_d = '0;
               ev_d  = 1'b1;
            end else if (ref_e) begin
               state_d = REF_LEAD;
               cnt_d   = ONE;
            end else if (fb_e) begin
               state_d = FB_LEAD;
               cnt_d   = ONE;
            end
         end
         REF_LEAD: begin
            if (fb_e) begin
               err_d   = lead_mag;
               ev_d    = 1'b1;
               state_d = ref_e ? REF_LEAD : IDLE;
               cnt_d   = ref_e ? ONE : '0;
            end else if (ref_e) begin
               slip_d = 1'b1;
               err_d  = {1'b0, MAX_WAIT};
               ev_d   = 1'b1;
               cnt_d  = ONE;
            end else if (cnt_q == MAX_WAIT) begin
               slip_d  = 1'b1;
               err_d   = {1'b0, MAX_WAIT};
               ev_d    = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         FB_LEAD: begin
            if (ref_e) begin
               err_d   = '0 - lead_mag;
               ev_d    = 1'b1;
               state_d = fb_e ? FB_LEAD : IDLE;
               cnt_d   = fb_e ? ONE : '0;
            end else if (fb_e) begin
               slip_d = 1'b1;
               err_d  = '0 - {1'b0, MAX_WAIT};
               ev_d   = 1'b1;
               cnt_d  = ONE;
            end else if (cnt_q == MAX_WAIT) begin
               slip_d  = 1'b1;
               err_d   = '0 - {1'b0, MAX_WAIT};
               ev_d    = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      err_abs = err_d[CNT_W] ? ('0 - err_d) : err_d;
      if (ev_d) begin
         if (!slip_d && (err_abs <= TOL)) begin
            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 8'd1;
            locked_d   = (lock_cnt_d == LOCK_MAX);
         end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
         end
      end

      // disabling freezes phase_err but leaves the synchronisers running
      if (!enable) begin
         state_d    = IDLE;
         cnt_d      = '0;
         err_d      = err_q;
         ev_d       = 1'b0;
         slip_d     = 1'b0;
         lock_cnt_d = '0;
         locked_d   = 1'b0;
      end
      up_d = (state_d == REF_LEAD);
      dn_d = (state_d == FB_LEAD);
   end

   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ref_sh_q   <= '0;
         fb_sh_q    <= '0;
         cnt_q      <= '0;
         lock_cnt_q <= '0;
         err_q      <= '0;
         up_q       <= 1'b0;
         dn_q       <= 1'b0;
         ev_q       <= 1'b0;
         slip_q     <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ref_sh_q   <= ref_sh_d;
         fb_sh_q    <= fb_sh_d;
         cnt_q      <= cnt_d;
         lock_cnt_q <= lock_cnt_d;
         err_q      <= err_d;
         up_q       <= up_d;
         dn_q       <= dn_d;
         ev_q       <= ev_d;
         slip_q     <= slip_d;
         locked_q   <= locked_d;
      end
   end

   assign up        = up_q;
   assign dn        = dn_q;
   assign phase_err = err_q;
   assign err_valid = ev_q;
   assign slip      = slip_q;
   assign locked    = locked_q;
endmodule

// File: tb/tb_pll_phase_detector.sv
// Bench for pll_phase_detector: directed vector table, hand sequences, randomized traffic vs. a lead-count model.
module tb_pll_phase_detector;
   localparam int MAXW = 255;

   logic       sys_clock = 1'b0;
   logic       reset_n, enable, ref_in, fb_in;
   logic       up, dn, err_valid, slip, locked;
   logic [8:0] phase_err;

   always #5 sys_clock = ~sys_clock;

   pll_phase_detector #(.CNT_W(8), .LOCK_TOL(2), .LOCK_COUNT(16)) dut (
      .sys_clock(sys_clock), .reset_n(reset_n), .enable(enable),
      .ref_in(ref_in), .fb_in(fb_in), .up(up), .dn(dn),
      .phase_err(phase_err), .err_valid(err_valid), .slip(slip), .locked(locked)
   );

   int checks = 0;
   int errors = 0;

   // Model: signed lead in sample cycles (>0 ref waiting for fb, <0 fb waiting for ref)
   int       m_lead, m_err, m_run;
   bit       m_ev, m_slip, m_locked;
   bit [3:0] rh, fh;
   bit       en_lvl;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_lead = 0; m_err = 0; m_run = 0;
      m_ev = 0; m_slip = 0; m_locked = 0;
      rh = '0; fh = '0;
   endfunction

   function automatic void measure(int e, bit s);
      m_err = e; m_ev = 1; m_slip = s;
   endfunction

   function automatic void model_step(bit r, bit f, bit en);
      bit re, fe;
      rh = {rh[2:0], r};
      fh = {fh[2:0], f};
      re = rh[2] & ~rh[3];
      fe = fh[2] & ~fh[3];
      m_ev = 0; m_slip = 0;
      if (!en) begin
         m_lead = 0; m_run = 0; m_locked = 0;
         return;
      end
      if (m_lead == 0) begin
         if (re && fe) measure(0, 0);
         else if (re) m_lead = 1;
         else if (fe) m_lead = -1;
      end else if (m_lead > 0) begin
         if (fe) begin measure(m_lead, 0); m_lead = re ? 1 : 0; end
         else if (re) begin measure(MAXW, 1); m_lead = 1; end
         else if (m_lead == MAXW) begin measure(MAXW, 1); m_lead = 0; end
         else m_lead = m_lead + 1;
      end else begin
         if (re) begin measure(m_lead, 0); m_lead = fe ? -1 : 0; end
         else if (fe) begin measure(-MAXW, 1); m_lead = -1; end
         else if (m_lead == -MAXW) begin measure(-MAXW, 1); m_lead = 0; end
         else m_lead = m_lead - 1;
      end
      if (m_ev) begin
         if (!m_slip && m_err >= -2 && m_err <= 2) begin
            if (m_run < 16) m_run = m_run + 1;
            m_locked = (m_run == 16);
         end else begin
            m_run = 0; m_locked = 0;
         end
      end
   endfunction

   // one sample cycle: drive, let the edge happen, compare every output at the falling edge
   task automatic tick(input bit r, input bit f);
      logic [13:0] exp;
      ref_in = r; fb_in = f; enable = en_lvl;
      @(posedge sys_clock);
      model_step(r, f, en_lvl);
      @(negedge sys_clock);
      exp = {m_lead > 0, m_lead < 0, m_err[8:0], m_ev, m_slip, m_locked};
      check("model", 32'({up, dn, phase_err, err_valid, slip, locked}), 32'(exp));
   endtask

   task automatic run_pair(input int ra, input int fa, output int upc, output int dnc,
                           output int evc, output logic [8:0] err);
      int last;
      last = ((ra > fa) ? ra : fa) + 6;
      upc = 0; dnc = 0; evc = 0; err = '0;
      for (int c = 0; c <= last + 6; c++) begin
         tick(c >= ra && c <= last, c >= fa && c <= last);
         upc += int'(up);
         dnc += int'(dn);
         evc += int'(err_valid);
         if (err_valid) err = phase_err;
      end
   endtask

   typedef struct {
      int         ra;
      int         fa;
      logic [8:0] err;
      int         upc;
      int         dnc;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int upc, dnc, evc, slips, evn, d, ra, fa;
      logic [8:0] err, held;

      tbl[0] = '{0, 5, 9'd5, 5, 0};
      tbl[1] = '{3, 0, 9'h1FD, 0, 3};
      tbl[2] = '{2, 2, 9'd0, 0, 0};
      tbl[3] = '{0, 1, 9'd1, 1, 0};
      tbl[4] = '{0, 100, 9'd100, 100, 0};
      tbl[5] = '{40, 0, 9'h1D8, 0, 40};

      reset_n = 1'b0; enable = 1'b1; en_lvl = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
      model_reset();
      repeat (3) @(posedge sys_clock);
      @(negedge sys_clock);
      check("reset_state", 32'({up, dn, phase_err, err_valid, slip, locked}), 32'(0));
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         run_pair(tbl[i].ra, tbl[i].fa, upc, dnc, evc, err);
         check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
         check($sformatf("vec%0d_up", i), 32'(upc), 32'(tbl[i].upc));
         check($sformatf("vec%0d_dn", i), 32'(dnc), 32'(tbl[i].dnc));
         check($sformatf("vec%0d_ev", i), 32'(evc), 32'(1));
      end

      // asynchronous reset while ref leads
      for (int i = 0; i < 10 && !up; i++) tick(1, 0);
      check("reset_pre_up", 32'(up), 32'(1));
      #2 reset_n = 1'b0;
      #1 check("reset_async", 32'({up, dn, phase_err, locked}), 32'(0));
      ref_in = 1'b0;
      model_reset();
      repeat (2) @(posedge sys_clock);
      @(negedge sys_clock);
      reset_n = 1'b1;
      repeat (3) tick(0, 0);

      // enable low mid-measurement, then re-enable with ref already high
      repeat (6) tick(1, 0);
      check("en_pre_up", 32'(up), 32'(1));
      held = phase_err;
      en_lvl = 1'b0;
      repeat (4) tick(1, 0);
      check("en_off_up", 32'(up), 32'(0));
      check("en_off_hold", 32'(phase_err), 32'(held));
      en_lvl = 1'b1;
      repeat (5) tick(1, 0);
      check("en_no_false_edge", 32'(up), 32'(0));
      repeat (5) tick(0, 0);

      // second ref edge without fb, then timeout
      slips = 0;
      for (int c = 0; c < 300; c++) begin
         tick(c < 2 || (c >= 10 && c < 12), 0);
         if (slip) begin
            slips++;
            check("slip_err", 32'(phase_err), 32'(MAXW));
         end
      end
      check("slip_count", 32'(slips), 32'(2));

      // 16 small errors lock, a 17th outside tolerance unlocks
      evn = 0;
      for (int k = 0; k < 17; k++) begin
         d = (k < 16) ? 1 : 4;
         for (int c = 0; c < 12; c++) begin
            tick(c < 6, c >= d && c < d + 6);
            if (err_valid) begin
               evn++;
               check($sformatf("lock_ev%0d", evn), 32'(locked), 32'(evn == 16));
            end
         end
      end
      check("lock_ev_total", 32'(evn), 32'(17));

      // jittered periodic edges
      for (int k = 0; k < 40; k++) begin
         ra = $urandom_range(0, 2);
         fa = $urandom_range(0, 2);
         for (int c = 0; c < 20; c++) tick(c >= ra && c < ra + 8, c >= fa && c < fa + 8);
      end

      // random toggling with occasional disable
      begin
         bit r, f;
         r = 0; f = 0;
         for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) r = ~r;
            if ($urandom_range(0, 9) == 0) f = ~f;
            en_lvl = ($urandom_range(0, 39) != 0);
            tick(r, f);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
